// File: rtl/sa_pkg.sv
// Shared constants for the systolic-array processing elements: default widths,
// pipeline depth limits and saturation-limit helpers used when PE_PSUM_SAT_EN is defined.
package sa_pkg;

    localparam int DEF_ACT_W   = 8;
    localparam int DEF_WGT_W   = 8;
    localparam int DEF_PSUM_W  = 32;
    localparam int DEF_MAC_LAT = 3;
    localparam int MIN_MAC_LAT = 1;
    localparam int MAX_MAC_LAT = 6;
    localparam int MAX_PSUM_W  = 64;

    // Largest representable value of a w-bit signed or unsigned accumulator.
    function automatic logic [MAX_PSUM_W-1:0] sat_max(input int w, input bit sgn);
        logic [MAX_PSUM_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_PSUM_W; i++) begin
            if (i < (sgn ? w - 1 : w)) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [MAX_PSUM_W-1:0] sat_min(input int w, input bit sgn);
        logic [MAX_PSUM_W-1:0] r;
        r = '0;
        if (sgn) r[w-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/sa_pe_mac.sv
// MAC pipeline for one PE: multiply, extend, add, then MAC_LAT register stages.
// With PE_PSUM_SAT_EN defined the add saturates instead of wrapping.
module sa_pe_mac
    import sa_pkg::*;
#(
    parameter int ACT_W       = DEF_ACT_W,
    parameter int WGT_W       = DEF_WGT_W,
    parameter int PSUM_W      = DEF_PSUM_W,
    parameter int MAC_LAT     = DEF_MAC_LAT,
    parameter int SIGNED_MODE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              act_vld,
    input  logic [ACT_W-1:0]  act,
    input  logic [WGT_W-1:0]  wgt,
    input  logic [PSUM_W-1:0] psum,
    output logic [PSUM_W-1:0] sum,
    output logic              sum_vld
);

    localparam int PW  = ACT_W + WGT_W;
    localparam bit SGN = (SIGNED_MODE != 0);

    logic [PW-1:0]     prod;
    logic [PSUM_W-1:0] prod_ext;
    logic [PSUM_W-1:0] sum_next;

    generate
        if (SGN) begin : g_signed
            always_comb begin
                prod     = PW'($signed(act)) * PW'($signed(wgt));
                prod_ext = PSUM_W'($signed(prod));
            end
        end else begin : g_unsigned
            always_comb begin
                prod     = PW'(act) * PW'(wgt);
                prod_ext = PSUM_W'(prod);
            end
        end
    endgenerate

`ifdef PE_PSUM_SAT_EN
    localparam logic [PSUM_W-1:0] SAT_HI = PSUM_W'(sat_max(PSUM_W, SGN));
    localparam logic [PSUM_W-1:0] SAT_LO = PSUM_W'(sat_min(PSUM_W, SGN));

    logic [PSUM_W:0] wide;
    logic            ovf;

    // One guard bit exposes overflow: sign disagreement when signed, carry-out when unsigned.
    always_comb begin
        wide = {SGN & psum[PSUM_W-1], psum} + {SGN & prod_ext[PSUM_W-1], prod_ext};
        ovf  = SGN ? (wide[PSUM_W] ^ wide[PSUM_W-1]) : wide[PSUM_W];
        if (!ovf)
            sum_next = wide[PSUM_W-1:0];
        else if (SGN && wide[PSUM_W])
            sum_next = SAT_LO;
        else
            sum_next = SAT_HI;
    end
`else
    assign sum_next = psum + prod_ext;
`endif

    logic [PSUM_W-1:0]  sum_pipe [MAC_LAT];
    logic [MAC_LAT-1:0] vld_pipe;

    // Invalid slots carry zero so the tail of the pipe is already clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < MAC_LAT; i++) sum_pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= act_vld;
            sum_pipe[0] <= act_vld ? sum_next : '0;
            for (int i = 1; i < MAC_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                sum_pipe[i] <= sum_pipe[i-1];
            end
        end
    end

    assign sum     = sum_pipe[MAC_LAT-1];
    assign sum_vld = vld_pipe[MAC_LAT-1];

endmodule

// File: rtl/sa_pe_db.sv
// Double-buffered-weight systolic PE: owns shadow/active weights, forwarding and swap.
// Build option: PE_PSUM_SAT_EN makes the partial-sum add saturate (see sa_pe_mac).
module sa_pe_db
    import sa_pkg::*;
#(
    parameter int ACT_W       = DEF_ACT_W,
    parameter int WGT_W       = DEF_WGT_W,
    parameter int PSUM_W      = DEF_PSUM_W,
    parameter int MAC_LAT     = DEF_MAC_LAT,
    parameter int SIGNED_MODE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WGT_W-1:0]  in_wgt,
    input  logic              in_wgt_vld,
    output logic [WGT_W-1:0]  out_wgt,
    output logic              out_wgt_vld,
    input  logic              in_swap,
    output logic              out_swap,
    input  logic [ACT_W-1:0]  in_act,
    input  logic              in_act_vld,
    output logic [ACT_W-1:0]  out_act,
    output logic              out_act_vld,
    input  logic [PSUM_W-1:0] in_psum,
    output logic [PSUM_W-1:0] out_psum,
    output logic              out_psum_vld
);

    // All streams are valid-only with no ready: every slot with its valid high is
    // consumed on the edge it is presented, and valid-low slots pass through as bubbles.

    logic [WGT_W-1:0]   shadow;
    logic [WGT_W-1:0]   active;
    logic [ACT_W-1:0]   act_pipe [MAC_LAT];
    logic [MAC_LAT-1:0] act_vld_pipe;

    // A swap copies the pre-load shadow, so a same-edge load lands only in shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow       <= '0;
            active       <= '0;
            out_wgt      <= '0;
            out_wgt_vld  <= 1'b0;
            out_swap     <= 1'b0;
            act_vld_pipe <= '0;
            for (int i = 0; i < MAC_LAT; i++) act_pipe[i] <= '0;
        end else begin
            if (in_wgt_vld) shadow <= in_wgt;
            if (in_swap)    active <= shadow;
            out_wgt         <= in_wgt_vld ? in_wgt : '0;
            out_wgt_vld     <= in_wgt_vld;
            out_swap        <= in_swap;
            act_vld_pipe[0] <= in_act_vld;
            act_pipe[0]     <= in_act_vld ? in_act : '0;
            for (int i = 1; i < MAC_LAT; i++) begin
                act_vld_pipe[i] <= act_vld_pipe[i-1];
                act_pipe[i]     <= act_pipe[i-1];
            end
        end
    end

    assign out_act     = act_pipe[MAC_LAT-1];
    assign out_act_vld = act_vld_pipe[MAC_LAT-1];

    sa_pe_mac #(
        .ACT_W       (ACT_W),
        .WGT_W       (WGT_W),
        .PSUM_W      (PSUM_W),
        .MAC_LAT     (MAC_LAT),
        .SIGNED_MODE (SIGNED_MODE)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .act_vld (in_act_vld),
        .act     (in_act),
        .wgt     (active),
        .psum    (in_psum),
        .sum     (out_psum),
        .sum_vld (out_psum_vld)
    );

endmodule
